// File: rtl/battleship_pkg.sv
// ---------------------------------------------------------------------------
// battleship_pkg
// Shared types and constants for the Battleship datapath (cursor controller,
// board store "tablero" and the VGA renderer).
//   BOARD_SIZE   : cells per row/column, legal coordinates 0..BOARD_SIZE-1
//   coord_t      : 3-bit unsigned board coordinate
//   req_type_e   : request kind sent to the board store
//   ctrl_state_e : cursor-controller request FSM states
// ---------------------------------------------------------------------------
package battleship_pkg;

    localparam int BOARD_SIZE = 5;

    typedef logic [2:0] coord_t;

    typedef enum logic {
        PLACE = 1'b0,
        FIRE  = 1'b1
    } req_type_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_ACK = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
// Turns one raw, bouncing, asynchronous push-button into a clean single-cycle
// pulse on each accepted press.
//   clk      in  system clock
//   rst      in  asynchronous active-low reset (button treated as released)
//   i_btn    in  raw button level, active-high
//   o_pulse  out 1-cycle pulse per accepted 0->1 transition
// Press-to-pulse latency is DEBOUNCE_CYCLES+3 clocks: 2 synchronizer stages,
// DEBOUNCE_CYCLES differing samples to flip the stable level, 1 edge register.
// ---------------------------------------------------------------------------
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_pulse
);

    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic          r_stable_d;
    logic          r_pulse;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
            r_pulse    <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            // Count consecutive samples that disagree with the accepted level;
            // any agreeing sample (a bounce back) restarts the count.
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            r_stable_d <= r_stable;
            r_pulse    <= r_stable & ~r_stable_d;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/cursor_controller.sv
// ---------------------------------------------------------------------------
// cursor_controller
// Conditions the six player buttons, keeps the board cursor and issues
// place/fire requests to the board store, then latches the board's answer.
//   clk, rst                     clock, asynchronous active-low reset
//   move_up/down/left/right      raw direction buttons
//   player_move                  raw fire button
//   player_place_ship            raw place button
//   place_en, fire_en            game-phase enables from the main FSM
//   i_actual, j_actual           cursor row/column (to vga)
//   req_valid/req_ready          request handshake to the board
//   req_type, req_i, req_j       request kind and cursor snapshot
//   ack_valid, ack_ok            board result strobe and verdict
//   result_valid, result_ok      1-cycle result pulse, held verdict
//   busy                         request in flight (REQ or WAIT_ACK)
// ---------------------------------------------------------------------------
module cursor_controller
    import battleship_pkg::*;
#(
    parameter int BOARD_SIZE      = battleship_pkg::BOARD_SIZE,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       move_up,
    input  logic       move_down,
    input  logic       move_left,
    input  logic       move_right,
    input  logic       player_move,
    input  logic       player_place_ship,
    input  logic       place_en,
    input  logic       fire_en,
    output logic [2:0] i_actual,
    output logic [2:0] j_actual,
    output logic       req_valid,
    output logic       req_type,
    output logic [2:0] req_i,
    output logic [2:0] req_j,
    input  logic       req_ready,
    input  logic       ack_valid,
    input  logic       ack_ok,
    output logic       result_valid,
    output logic       result_ok,
    output logic       busy
);

    localparam coord_t C_MAX = coord_t'(BOARD_SIZE - 1);

    logic [5:0]  w_raw;
    logic [5:0]  w_pulse;
    logic        w_up, w_down, w_left, w_right, w_fire, w_place;

    ctrl_state_e r_state, w_state_nxt;
    req_type_e   r_req_type, w_type_nxt;
    coord_t      r_i, r_j, w_i_nxt, w_j_nxt;
    coord_t      r_req_i, r_req_j;
    logic        r_result_valid, r_result_ok;

    assign w_raw = {player_place_ship, player_move, move_right, move_left, move_down, move_up};

    for (genvar g = 0; g < 6; g++) begin : g_btn
        button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
            .clk    (clk),
            .rst    (rst),
            .i_btn  (w_raw[g]),
            .o_pulse(w_pulse[g])
        );
    end

    assign {w_place, w_fire, w_right, w_left, w_down, w_up} = w_pulse;

    // Cursor next value: only in IDLE, one direction per cycle by priority,
    // clamped at the edges (compare before stepping so no overflow is formed).
    always_comb begin
        w_i_nxt = r_i;
        w_j_nxt = r_j;
        if (r_state == IDLE) begin
            if (w_up) begin
                if (r_i != '0) w_i_nxt = r_i - coord_t'(1);
            end else if (w_down) begin
                if (r_i != C_MAX) w_i_nxt = r_i + coord_t'(1);
            end else if (w_left) begin
                if (r_j != '0) w_j_nxt = r_j - coord_t'(1);
            end else if (w_right) begin
                if (r_j != C_MAX) w_j_nxt = r_j + coord_t'(1);
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        w_type_nxt  = r_req_type;
        case (r_state)
            IDLE: begin
                if (w_place && place_en) begin
                    w_state_nxt = REQ;
                    w_type_nxt  = PLACE;
                end else if (w_fire && fire_en) begin
                    w_state_nxt = REQ;
                    w_type_nxt  = FIRE;
                end
            end
            REQ:      if (req_ready) w_state_nxt = WAIT_ACK;
            WAIT_ACK: if (ack_valid) w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        req_valid = (r_state == REQ);
        busy      = (r_state != IDLE);
    end

    // Cursor, request snapshot and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_i            <= '0;
            r_j            <= '0;
            r_req_type     <= PLACE;
            r_req_i        <= '0;
            r_req_j        <= '0;
            r_result_valid <= 1'b0;
            r_result_ok    <= 1'b0;
        end else begin
            r_i <= w_i_nxt;
            r_j <= w_j_nxt;
            // Snapshot uses the post-move cursor so a same-cycle move counts.
            if (r_state == IDLE && w_state_nxt == REQ) begin
                r_req_type <= w_type_nxt;
                r_req_i    <= w_i_nxt;
                r_req_j    <= w_j_nxt;
            end
            r_result_valid <= (r_state == WAIT_ACK) && ack_valid;
            if (r_state == WAIT_ACK && ack_valid) r_result_ok <= ack_ok;
        end
    end

    assign i_actual     = r_i;
    assign j_actual     = r_j;
    assign req_type     = r_req_type;
    assign req_i        = r_req_i;
    assign req_j        = r_req_j;
    assign result_valid = r_result_valid;
    assign result_ok    = r_result_ok;

endmodule

// File: tb/tb_cursor_controller.sv
// ---------------------------------------------------------------------------
// tb_cursor_controller
// Directed, table-driven bench for cursor_controller (DEBOUNCE_CYCLES=4,
// BOARD_SIZE=5). Inputs change on the falling edge, outputs are read there too.
// Button vector bits: 0 up, 1 down, 2 left, 3 right, 4 fire, 5 place.
// ---------------------------------------------------------------------------
module tb_cursor_controller;

    localparam logic [5:0] B_U = 6'b000001;
    localparam logic [5:0] B_D = 6'b000010;
    localparam logic [5:0] B_L = 6'b000100;
    localparam logic [5:0] B_R = 6'b001000;
    localparam logic [5:0] B_F = 6'b010000;
    localparam logic [5:0] B_P = 6'b100000;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] btn;
    logic       place_en, fire_en, req_ready, ack_valid, ack_ok;
    logic [2:0] i_actual, j_actual, req_i, req_j;
    logic       req_valid, req_type, result_valid, result_ok, busy;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [5:0] btn;
        logic [2:0] ei;
        logic [2:0] ej;
    } vec_t;

    vec_t tbl [12];

    always #5 clk = ~clk;

    cursor_controller #(.BOARD_SIZE(5), .DEBOUNCE_CYCLES(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .move_up          (btn[0]),
        .move_down        (btn[1]),
        .move_left        (btn[2]),
        .move_right       (btn[3]),
        .player_move      (btn[4]),
        .player_place_ship(btn[5]),
        .place_en         (place_en),
        .fire_en          (fire_en),
        .i_actual         (i_actual),
        .j_actual         (j_actual),
        .req_valid        (req_valid),
        .req_type         (req_type),
        .req_i            (req_i),
        .req_j            (req_j),
        .req_ready        (req_ready),
        .ack_valid        (ack_valid),
        .ack_ok           (ack_ok),
        .result_valid     (result_valid),
        .result_ok        (result_ok),
        .busy             (busy)
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold long enough for the press to be accepted and acted on, then
    // release long enough for the release to be accepted too.
    task automatic press(input logic [5:0] b);
        btn = b;
        tick(8);
        btn = '0;
        tick(8);
    endtask

    task automatic handshake(input string nm, input logic ok);
        req_ready = 1'b1;
        tick(1);
        req_ready = 1'b0;
        chk({nm, "_vld_drop"}, req_valid, 1'b0);
        chk({nm, "_busy_wait"}, busy, 1'b1);
        tick(2);
        chk({nm, "_no_res"}, result_valid, 1'b0);
        ack_valid = 1'b1;
        ack_ok    = ok;
        tick(1);
        ack_valid = 1'b0;
        ack_ok    = 1'b0;
        chk({nm, "_res_vld"}, result_valid, 1'b1);
        chk({nm, "_res_ok"}, result_ok, ok);
        chk({nm, "_idle"}, busy, 1'b0);
        tick(1);
        chk({nm, "_res_pulse"}, result_valid, 1'b0);
        chk({nm, "_res_hold"}, result_ok, ok);
    endtask

    initial begin
        bit saw;
        rst = 1'b0; btn = '0; place_en = 1'b0; fire_en = 1'b0;
        req_ready = 1'b0; ack_valid = 1'b0; ack_ok = 1'b0;

        tbl[0]  = '{B_R,       3'd0, 3'd1};
        tbl[1]  = '{B_R,       3'd0, 3'd2};
        tbl[2]  = '{B_R,       3'd0, 3'd3};
        tbl[3]  = '{B_R,       3'd0, 3'd4};
        tbl[4]  = '{B_R,       3'd0, 3'd4};  // right edge clamp
        tbl[5]  = '{B_R,       3'd0, 3'd4};
        tbl[6]  = '{B_U,       3'd0, 3'd4};  // top edge clamp
        tbl[7]  = '{B_L,       3'd0, 3'd3};
        tbl[8]  = '{B_U | B_D, 3'd0, 3'd3};  // up beats down, clamps
        tbl[9]  = '{B_L | B_R, 3'd0, 3'd2};  // left beats right
        tbl[10] = '{B_D | B_L, 3'd1, 3'd2};  // down beats left
        tbl[11] = '{B_U | B_R, 3'd0, 3'd2};  // up beats right

        tick(3);
        chk("rst_i", i_actual, 3'd0);
        chk("rst_j", j_actual, 3'd0);
        chk("rst_req_valid", req_valid, 1'b0);
        chk("rst_req_type", req_type, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_result", {result_valid, result_ok}, 2'b00);
        rst = 1'b1;
        tick(2);

        // Cursor moves, clamping and direction priority
        for (int k = 0; k < 12; k++) begin
            press(tbl[k].btn);
            chk($sformatf("tbl%0d_i", k), i_actual, tbl[k].ei);
            chk($sformatf("tbl%0d_j", k), j_actual, tbl[k].ej);
            chk($sformatf("tbl%0d_busy", k), busy, 1'b0);
        end

        // Bouncing down button: nothing until 4 stable samples, then one step
        for (int c = 0; c < 20; c++) begin
            btn[1] = ((c % 4) < 2);
            tick(1);
        end
        chk("bnc_hold", i_actual, 3'd0);
        btn = B_D;
        tick(7);
        chk("bnc_pre", i_actual, 3'd0);
        tick(1);
        chk("bnc_post", i_actual, 3'd1);
        btn = '0;
        tick(8);
        chk("bnc_once", i_actual, 3'd1);

        press(B_D);
        press(B_R);
        chk("pos_i", i_actual, 3'd2);
        chk("pos_j", j_actual, 3'd3);

        // Place request with stalled ready; enable drop and stray ack ignored
        place_en = 1'b1;
        btn = B_P;
        tick(7);
        chk("plc_lat_pre", busy, 1'b0);
        tick(1);
        chk("plc_vld", req_valid, 1'b1);
        chk("plc_type", req_type, 1'b0);
        chk("plc_busy", busy, 1'b1);
        btn = '0;
        place_en = 1'b0;
        for (int c = 0; c < 5; c++) begin
            ack_valid = (c == 2);
            ack_ok    = 1'b1;
            tick(1);
            chk($sformatf("plc_stall%0d_vld", c), req_valid, 1'b1);
            chk($sformatf("plc_stall%0d_fld", c), {req_type, req_i, req_j}, {1'b0, 3'd2, 3'd3});
            chk($sformatf("plc_stall%0d_res", c), result_valid, 1'b0);
        end
        ack_valid = 1'b0;
        ack_ok    = 1'b0;
        handshake("plc", 1'b1);
        tick(8);

        // Fire without enable is ignored; with enable, a miss
        saw = 1'b0;
        btn = B_F;
        for (int c = 0; c < 16; c++) begin
            if (c == 8) btn = '0;
            tick(1);
            if (req_valid) saw = 1'b1;
        end
        chk("fire_dis", saw, 1'b0);
        fire_en = 1'b1;
        btn = B_F;
        tick(8);
        chk("fire_vld", req_valid, 1'b1);
        chk("fire_fld", {req_type, req_i, req_j}, {1'b1, 3'd2, 3'd3});
        btn = '0;
        handshake("fire", 1'b0);
        tick(8);

        // Left press during WAIT_ACK is dropped
        btn = B_F;
        tick(8);
        chk("wa_vld", req_valid, 1'b1);
        btn = '0;
        req_ready = 1'b1;
        tick(1);
        req_ready = 1'b0;
        btn = B_L;
        tick(8);
        chk("wa_j", j_actual, 3'd3);
        chk("wa_busy", busy, 1'b1);
        ack_valid = 1'b1;
        ack_ok    = 1'b1;
        tick(1);
        ack_valid = 1'b0;
        chk("wa_res", {result_valid, result_ok}, 2'b11);
        btn = '0;
        tick(10);
        chk("wa_j_after", j_actual, 3'd3);

        // Place and fire together: place wins
        place_en = 1'b1;
        btn = B_P | B_F;
        tick(8);
        chk("both_vld", req_valid, 1'b1);
        chk("both_type", req_type, 1'b0);
        btn = '0;
        handshake("both", 1'b1);
        tick(8);

        // Async reset in REQ, then stray ack ignored
        place_en = 1'b0;
        btn = B_F;
        tick(8);
        chk("rr_vld", req_valid, 1'b1);
        chk("rr_type", req_type, 1'b1);
        btn = '0;
        tick(3);
        chk("rr_still", req_valid, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("rr_async_vld", req_valid, 1'b0);
        chk("rr_async_busy", busy, 1'b0);
        chk("rr_async_req", {req_type, req_i, req_j}, 7'd0);
        chk("rr_async_cur", {i_actual, j_actual}, 6'd0);
        chk("rr_async_res", {result_valid, result_ok}, 2'b00);
        @(negedge clk);
        rst = 1'b1;
        tick(2);
        ack_valid = 1'b1;
        ack_ok    = 1'b1;
        tick(1);
        ack_valid = 1'b0;
        ack_ok    = 1'b0;
        chk("stray_res", {result_valid, result_ok}, 2'b00);
        chk("stray_busy", busy, 1'b0);
        tick(1);
        chk("stray_res2", result_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
